// File: rtl/topolar_if.sv
// Sample/result bundle for the vectoring CORDIC: pipeline enable, the
// rectangular input sample with its sideband bit, and the polar result.
interface topolar_if #(
   parameter int IW = 13,
   parameter int OW = 15,
   parameter int PW = 20
);
   logic                 i_ce;
   logic signed [IW-1:0] i_xval;
   logic signed [IW-1:0] i_yval;
   logic                 i_aux;
   logic [OW-1:0]        o_mag;
   logic [PW-1:0]        o_phase;
   logic                 o_aux;

   // Sample source / result consumer side
   modport master (
      output i_ce, i_xval, i_yval, i_aux,
      input  o_mag, o_phase, o_aux
   );

   // CORDIC core side
   modport slave (
      input  i_ce, i_xval, i_yval, i_aux,
      output o_mag, o_phase, o_aux
   );
endinterface

// File: rtl/topolar.sv
// Pipelined vectoring-mode CORDIC: rectangular (x, y) to magnitude and phase.
// Magnitude carries the uncompensated CORDIC gain (~1.64676); phase uses
// 2^PW units per full turn. Every register advances only on i_ce.
module topolar #(
   parameter int IW      = 13,
   parameter int OW      = 15,
   parameter int WW      = 18,
   parameter int PW      = 20,
   parameter int NSTAGES = 16
) (
   input  logic     i_clk,
   input  logic     i_reset_n,
   topolar_if.slave bus
);
   localparam int FRAC  = 3;              // fractional bits below the input LSB
   localparam int GUARD = WW - IW - FRAC; // headroom bits above the input MSB
   localparam int DROP  = WW - OW;        // LSBs removed by output rounding

   // atan(2^-idx) in 2^20-per-turn units; stages beyond the table get 0
   function automatic logic [PW-1:0] f_angle(input int idx);
      logic [19:0] a;
      case (idx)
         0:       a = 20'h20000;
         1:       a = 20'h12E40;
         2:       a = 20'h09FB3;
         3:       a = 20'h05111;
         4:       a = 20'h028B0;
         5:       a = 20'h0145D;
         6:       a = 20'h00A2F;
         7:       a = 20'h00517;
         8:       a = 20'h0028B;
         9:       a = 20'h00145;
         10:      a = 20'h000A2;
         11:      a = 20'h00051;
         12:      a = 20'h00028;
         13:      a = 20'h00014;
         14:      a = 20'h0000A;
         15:      a = 20'h00005;
         default: a = 20'h00000;
      endcase
      return PW'(a);
   endfunction

   // Stage chain: index 0 is the folded input, index NSTAGES the last iteration
   logic signed [WW-1:0] w_x  [0:NSTAGES];
   logic signed [WW-1:0] w_y  [0:NSTAGES];
   logic [PW-1:0]        w_ph [0:NSTAGES];

   logic signed [WW-1:0] w_x_e, w_y_e, w_x_fold, w_y_fold;
   logic [PW-1:0]        w_ph_fold;
   logic signed [WW-1:0] r_x0, r_y0;
   logic [PW-1:0]        r_ph0;
   logic [NSTAGES:0]     r_aux_chain;
   logic [OW-1:0]        r_mag;
   logic [PW-1:0]        r_phase;
   logic                 r_aux_out;
   logic                 w_round_up;
   logic [OW-1:0]        w_mag_rnd;

   assign w_x_e = {{GUARD{bus.i_xval[IW-1]}}, bus.i_xval, {FRAC{1'b0}}};
   assign w_y_e = {{GUARD{bus.i_yval[IW-1]}}, bus.i_yval, {FRAC{1'b0}}};

   // Quadrant fold into the right half-plane by exact +/-90 degree rotations
   always_comb begin
      w_x_fold  = w_x_e;
      w_y_fold  = w_y_e;
      w_ph_fold = '0;
      if (w_x_e[WW-1]) begin
         if (!w_y_e[WW-1]) begin
            w_x_fold  = w_y_e;
            w_y_fold  = -w_x_e;
            w_ph_fold = PW'(1) << (PW-2);
         end else begin
            w_x_fold  = -w_y_e;
            w_y_fold  = w_x_e;
            w_ph_fold = PW'(3) << (PW-2);
         end
      end
   end

   // Stage 0 register: captures the folded sample
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_x0  <= '0;
         r_y0  <= '0;
         r_ph0 <= '0;
      end else if (bus.i_ce) begin
         r_x0  <= w_x_fold;
         r_y0  <= w_y_fold;
         r_ph0 <= w_ph_fold;
      end
   end

   assign w_x[0]  = r_x0;
   assign w_y[0]  = r_y0;
   assign w_ph[0] = r_ph0;

   genvar gi;
   generate
      for (gi = 0; gi < NSTAGES; gi++) begin : g_stage
         localparam logic [PW-1:0] LP_ANGLE = f_angle(gi);
         logic signed [WW-1:0] r_x, r_y;
         logic [PW-1:0]        r_ph;

         if (LP_ANGLE == '0) begin : g_pass
            // Zero-angle stage: delay only, keeps the latency constant
            always_ff @(posedge i_clk or negedge i_reset_n) begin
               if (!i_reset_n) begin
                  r_x  <= '0;
                  r_y  <= '0;
                  r_ph <= '0;
               end else if (bus.i_ce) begin
                  r_x  <= w_x[gi];
                  r_y  <= w_y[gi];
                  r_ph <= w_ph[gi];
               end
            end
         end else begin : g_iter
            // Micro-rotation driving y toward zero, accumulating the angle
            always_ff @(posedge i_clk or negedge i_reset_n) begin
               if (!i_reset_n) begin
                  r_x  <= '0;
                  r_y  <= '0;
                  r_ph <= '0;
               end else if (bus.i_ce) begin
                  if (!w_y[gi][WW-1]) begin
                     r_x  <= w_x[gi] + (w_y[gi] >>> gi);
                     r_y  <= w_y[gi] - (w_x[gi] >>> gi);
                     r_ph <= w_ph[gi] + LP_ANGLE;
                  end else begin
                     r_x  <= w_x[gi] - (w_y[gi] >>> gi);
                     r_y  <= w_y[gi] + (w_x[gi] >>> gi);
                     r_ph <= w_ph[gi] - LP_ANGLE;
                  end
               end
            end
         end

         assign w_x[gi+1]  = r_x;
         assign w_y[gi+1]  = r_y;
         assign w_ph[gi+1] = r_ph;
      end
   endgenerate

   // Half-to-even: round up above half, or at exactly half when the kept LSB is odd.
   // x is non-negative and has spare headroom, so the increment cannot overflow.
   assign w_round_up = w_x[NSTAGES][DROP-1] &
                       (w_x[NSTAGES][DROP] | (|w_x[NSTAGES][DROP-2:0]));
   assign w_mag_rnd  = OW'(w_x[NSTAGES][WW-1:DROP]) + OW'(w_round_up);

   // Sideband chain, one bit per pipeline register ahead of the output
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_aux_chain <= '0;
      end else if (bus.i_ce) begin
         r_aux_chain <= {r_aux_chain[NSTAGES-1:0], bus.i_aux};
      end
   end

   // Output register: rounded magnitude, raw phase, aligned sideband
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_mag     <= '0;
         r_phase   <= '0;
         r_aux_out <= 1'b0;
      end else if (bus.i_ce) begin
         r_mag     <= w_mag_rnd;
         r_phase   <= w_ph[NSTAGES];
         r_aux_out <= r_aux_chain[NSTAGES];
      end
   end

   assign bus.o_mag   = r_mag;
   assign bus.o_phase = r_phase;
   assign bus.o_aux   = r_aux_out;
endmodule

// File: tb/tb_topolar.sv
// Self-checking bench for topolar: directed vector table, a few random
// vectors against a floating-point model, and i_ce / reset sequences.
module tb_topolar;
   localparam int  IW  = 13;
   localparam int  OW  = 15;
   localparam int  PW  = 20;
   localparam int  LAT = 18;
   localparam real K   = 1.6467602581210654;
   localparam real PI  = 3.141592653589793;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   topolar_if #(.IW(IW), .OW(OW), .PW(PW)) bus ();

   topolar #(.IW(IW), .OW(OW), .WW(18), .PW(PW), .NSTAGES(16)) u_dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   typedef struct {
      logic signed [IW-1:0] x;
      logic signed [IW-1:0] y;
      int exp_mag;
      int exp_ph;
      int mtol;
      int ptol;
   } vec_t;

   typedef struct {
      bit aux;
      int idx;
   } slot_t;

   vec_t  tbl[$];
   slot_t pipe[$];
   int    checks = 0;
   int    errors = 0;
   bit    held_aux = 1'b0;
   int    held_idx = -1;
   int    aux_seen = 0;

   function automatic vec_t mk(int x, int y, int m, int p, int mt, int pt);
      vec_t v;
      v.x = IW'(x); v.y = IW'(y);
      v.exp_mag = m; v.exp_ph = p; v.mtol = mt; v.ptol = pt;
      return v;
   endfunction

   task automatic check_val(string nm, int act, int exp, int tol);
      int d;
      checks++;
      d = act - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, act, exp, tol);
      end
   endtask

   task automatic check_ph(string nm, int act, int exp, int tol);
      int d;
      checks++;
      d = (act - exp) & 32'h000F_FFFF;
      if (d >= 32'h0008_0000) d = d - 32'h0010_0000;
      if (d < 0) d = -d;
      if (d > tol) begin
         errors++;
         $display("FAIL %s: got 0x%05h expected 0x%05h (tol 0x%0h)", nm, act, exp, tol);
      end
   endtask

   // One clock: drive at negedge, let the posedge act, sample at next negedge
   task automatic do_cycle(bit ce, int idx, bit aux);
      slot_t s;
      bus.i_ce   = ce;
      bus.i_xval = (idx >= 0) ? tbl[idx].x : '0;
      bus.i_yval = (idx >= 0) ? tbl[idx].y : '0;
      bus.i_aux  = aux;
      @(posedge clk);
      @(negedge clk);
      if (ce) begin
         s.aux = aux; s.idx = idx;
         pipe.push_back(s);
         if (pipe.size() == LAT) begin
            s = pipe.pop_front();
            held_aux = s.aux;
            held_idx = s.idx;
         end
         if (bus.o_aux) aux_seen++;
      end
      check_val("o_aux", int'(bus.o_aux), int'(held_aux), 0);
      if (held_aux) begin
         $display("out vec=%0d ce=%0d mag=%0d phase=0x%05h", held_idx, ce, bus.o_mag, bus.o_phase);
         check_val($sformatf("mag[%0d]", held_idx), int'(bus.o_mag),
                   tbl[held_idx].exp_mag, tbl[held_idx].mtol);
         check_ph($sformatf("phase[%0d]", held_idx), int'(bus.o_phase),
                  tbl[held_idx].exp_ph, tbl[held_idx].ptol);
      end
   endtask

   task automatic model_reset();
      pipe.delete();
      held_aux = 1'b0;
      held_idx = -1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, x, y, base_rand;
      real a;
      rst_n      = 1'b1;
      bus.i_ce   = 1'b1;
      bus.i_xval = 13'sd1000;
      bus.i_yval = 13'sd1000;
      bus.i_aux  = 1'b1;
      #2 rst_n = 1'b0;

      // Reset state: inputs active and clock running, outputs held at zero
      repeat (3) @(negedge clk);
      check_val("rst_mag", int'(bus.o_mag), 0, 0);
      check_val("rst_phase", int'(bus.o_phase), 0, 0);
      check_val("rst_aux", int'(bus.o_aux), 0, 0);
      rst_n = 1'b1;
      model_reset();

      // Directed vectors, hand-computed: mag = |v| * 1.64676
      tbl.push_back(mk(1000, 0, 1647, 20'h00000, 2, 32'h20));      // 0
      tbl.push_back(mk(0, 1000, 1647, 20'h40000, 2, 32'h20));      // 1
      tbl.push_back(mk(-1000, 0, 1647, 20'h80000, 2, 32'h20));     // 2
      tbl.push_back(mk(0, -1000, 1647, 20'hC0000, 2, 32'h20));     // 3
      tbl.push_back(mk(1000, -1000, 2329, 20'hE0000, 3, 32'h20));  // 4
      tbl.push_back(mk(-4096, -4096, 9539, 20'hA0000, 4, 32'h20)); // 5
      tbl.push_back(mk(0, 0, 0, 20'h47065, 0, 0));                 // 6: sum of all angles
      tbl.push_back(mk(1000, 1000, 2329, 20'h20000, 3, 32'h20));   // 7
      tbl.push_back(mk(-1000, 1000, 2329, 20'h60000, 3, 32'h20));  // 8
      tbl.push_back(mk(4095, 0, 6743, 20'h00000, 2, 32'h20));      // 9
      tbl.push_back(mk(0, -4096, 6745, 20'hC0000, 2, 32'h20));     // 10
      tbl.push_back(mk(-4096, 0, 6745, 20'h80000, 2, 32'h20));     // 11

      // Random vectors against a floating-point model, kept well above the noise floor
      base_rand = tbl.size();
      for (int i = 0; i < 40; i++) begin
         do begin
            x = int'($urandom_range(0, 8191)) - 4096;
            y = int'($urandom_range(0, 8191)) - 4096;
         end while (x * x + y * y < 3000 * 3000);
         a = $atan2(real'(y), real'(x));
         if (a < 0.0) a = a + 2.0 * PI;
         tbl.push_back(mk(x, y, int'($sqrt(real'(x * x + y * y)) * K),
                          int'(a * 1048576.0 / (2.0 * PI)) & 32'h000F_FFFF, 3, 32'h20));
      end
      n = tbl.size();
      $display("vectors: %0d directed, %0d random", base_rand, n - base_rand);

      // Back-to-back throughput: one vector per clock, then flush
      for (int i = 0; i < n; i++) do_cycle(1'b1, i, 1'b1);
      repeat (LAT + 2) do_cycle(1'b1, -1, 1'b0);

      // Single tagged sample with i_ce toggling; outputs must hold on i_ce=0
      aux_seen = 0;
      do_cycle(1'b1, 0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         do_cycle(1'b0, -1, 1'b0);
         do_cycle(1'b1, -1, 1'b0);
      end
      check_val("aux_pulse_count", aux_seen, 1, 0);

      // Fill the pipe with tagged samples so outputs are nonzero, then reset
      for (int i = 0; i < LAT + 4; i++) do_cycle(1'b1, 5, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_val("async_rst_mag", int'(bus.o_mag), 0, 0);
      check_val("async_rst_phase", int'(bus.o_phase), 0, 0);
      check_val("async_rst_aux", int'(bus.o_aux), 0, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // After release: o_aux low until new samples cover the full latency
      aux_seen = 0;
      for (int i = 0; i < LAT + 4; i++) do_cycle(1'b1, 0, 1'b1);
      check_val("post_rst_aux_count", aux_seen, 5, 0);
      repeat (LAT + 2) do_cycle(1'b1, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
